// File: rtl/std_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : std_gate_pkg
// Description : Shared constants for the AND2/BUF/INV primitive gate layer.
//               Holds the default lane count, the default pulse-shaper
//               delay depth and the per-bit reset value of the BUF chain.
// Revision    : 1.0  initial release
// ============================================================================
package std_gate_pkg;

    // Default number of independent lanes.
    localparam int STD_GATE_WIDTH_DEF = 8;

    // Default depth of the registered BUF chain (pulse width in clocks).
    localparam int STD_GATE_DLY_DEF   = 10;

    // Per-bit chain reset value. Replicated across the lane vector this
    // gives an all-ones load, which reads as "a was low" to the shaper.
    localparam logic STD_GATE_CHAIN_RST = 1'b1;

endpackage : std_gate_pkg
`default_nettype wire

// File: rtl/std_buf_chain.sv
`default_nettype none
// ============================================================================
// Module      : std_buf_chain
// Description : WIDTH x DELAY_STAGES synchronous shift register. Each lane
//               shifts i_d in at stage 0 and presents the last stage on
//               o_tail. A synchronous reset loads every stage with ones.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous active-high reset (loads ones)
//               i_d     - [WIDTH-1:0] per-lane input to stage 0
//               o_tail  - [WIDTH-1:0] per-lane output of the last stage
// Revision    : 1.0  initial release
// ============================================================================
module std_buf_chain
    import std_gate_pkg::*;
#(
    parameter int WIDTH        = STD_GATE_WIDTH_DEF,
    parameter int DELAY_STAGES = STD_GATE_DLY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_tail
);

    logic [WIDTH-1:0] r_chain [DELAY_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DELAY_STAGES; k++) begin
                r_chain[k] <= {WIDTH{STD_GATE_CHAIN_RST}};
            end
        end else begin
            r_chain[0] <= i_d;
            for (int k = 1; k < DELAY_STAGES; k++) begin
                r_chain[k] <= r_chain[k-1];
            end
        end
    end

    assign o_tail = r_chain[DELAY_STAGES-1];

endmodule : std_buf_chain
`default_nettype wire

// File: rtl/std_and2_buf_inv.sv
`default_nettype none
// ============================================================================
// Module      : std_and2_buf_inv
// Description : WIDTH-lane bank of AND2, BUF and INV primitives with
//               combinational and registered outputs, plus a clocked
//               rising-edge pulse shaper (INV -> BUF chain -> AND2).
//               Build option: define STD_GATE_PULSE_EN to build the pulse
//               shaper; when undefined no chain is built and pls is 0.
// Ports       : clk     - sole clock, rising edge
//               reset   - synchronous active-high reset
//               a, b    - [WIDTH-1:0] per-lane operands (b feeds AND2 only)
//               y_and/y_buf/y_inv - combinational a&b, a, ~a
//               q_and/q_buf/q_inv - registered a&b, a, ~a (reset to 0)
//               pls     - [WIDTH-1:0] rising-edge pulse, DELAY_STAGES wide
// Revision    : 1.0  initial release
// ============================================================================
module std_and2_buf_inv
    import std_gate_pkg::*;
#(
    parameter int WIDTH        = STD_GATE_WIDTH_DEF,
    parameter int DELAY_STAGES = STD_GATE_DLY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_buf,
    output logic [WIDTH-1:0] y_inv,
    output logic [WIDTH-1:0] q_and,
    output logic [WIDTH-1:0] q_buf,
    output logic [WIDTH-1:0] q_inv,
    output logic [WIDTH-1:0] pls
);

    logic [WIDTH-1:0] r_q_and;
    logic [WIDTH-1:0] r_q_buf;
    logic [WIDTH-1:0] r_q_inv;

    // Pure gate outputs: independent of clk and reset.
    assign y_and = a & b;
    assign y_buf = a;
    assign y_inv = ~a;

    // Registered copies. q_inv clears to 0 (not ~a) so every registered
    // output reads zero while held in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_and <= '0;
            r_q_buf <= '0;
            r_q_inv <= '0;
        end else begin
            r_q_and <= a & b;
            r_q_buf <= a;
            r_q_inv <= ~a;
        end
    end

    assign q_and = r_q_and;
    assign q_buf = r_q_buf;
    assign q_inv = r_q_inv;

`ifdef STD_GATE_PULSE_EN
    logic [WIDTH-1:0] w_inv_a;
    logic [WIDTH-1:0] w_tail;

    assign w_inv_a = ~a;

    // The tail holds ~a from DELAY_STAGES edges ago. ANDing it with the
    // live a gives a pulse that starts with the rise (no register in the
    // a path) and ends once the high level reaches the tail.
    std_buf_chain #(
        .WIDTH        (WIDTH),
        .DELAY_STAGES (DELAY_STAGES)
    ) u_buf_chain (
        .clk    (clk),
        .reset  (reset),
        .i_d    (w_inv_a),
        .o_tail (w_tail)
    );

    assign pls = a & w_tail;
`else
    // No chain in this build. DELAY_STAGES is still part of the interface
    // so both builds drop into the same instantiation; it has no hardware
    // here, and either branch ties the pulse output low.
    generate
        if (DELAY_STAGES >= 1) begin : g_pls_off
            assign pls = '0;
        end else begin : g_pls_off_bad_depth
            assign pls = '0;
        end
    endgenerate
`endif

endmodule : std_and2_buf_inv
`default_nettype wire

// File: tb/tb_std_and2_buf_inv.sv
`default_nettype none
// ============================================================================
// Module      : tb_std_and2_buf_inv
// Description : Scoreboard bench for std_and2_buf_inv (WIDTH=8,
//               DELAY_STAGES=10). The driver applies one input vector per
//               clock and queues the expected outputs for that cycle; the
//               monitor pops and compares on every falling edge. Pulse
//               lengths are also counted per lane and compared with
//               hand-derived widths. Expectations follow STD_GATE_PULSE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_std_and2_buf_inv;

    localparam int W = 8;
    localparam int D = 10;
`ifdef STD_GATE_PULSE_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    typedef struct packed {
        logic [W-1:0] y_and;
        logic [W-1:0] y_buf;
        logic [W-1:0] y_inv;
        logic [W-1:0] q_and;
        logic [W-1:0] q_buf;
        logic [W-1:0] q_inv;
        logic [W-1:0] pls;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [W-1:0] y_and, y_buf, y_inv, q_and, q_buf, q_inv, pls;

    std_and2_buf_inv #(.WIDTH(W), .DELAY_STAGES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y_and (y_and),
        .y_buf (y_buf),
        .y_inv (y_inv),
        .q_and (q_and),
        .q_buf (q_buf),
        .q_inv (q_inv),
        .pls   (pls)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pls_cnt [W];

    // Reference state: registered gates and the chain contents by definition.
    logic [W-1:0] m_q_and, m_q_buf, m_q_inv;
    logic [W-1:0] m_hist [D];
    logic [W-1:0] cur_a, cur_b;
    logic         cur_rst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req)
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
        else
            n_pass++;
    endtask

    // Monitor: every output is presented each cycle, so compare on each
    // falling edge that has a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("y_and", {24'd0, y_and}, {24'd0, e.y_and});
            chk("y_buf", {24'd0, y_buf}, {24'd0, e.y_buf});
            chk("y_inv", {24'd0, y_inv}, {24'd0, e.y_inv});
            chk("q_and", {24'd0, q_and}, {24'd0, e.q_and});
            chk("q_buf", {24'd0, q_buf}, {24'd0, e.q_buf});
            chk("q_inv", {24'd0, q_inv}, {24'd0, e.q_inv});
            chk("pls",   {24'd0, pls},   {24'd0, e.pls});
            for (int i = 0; i < W; i++)
                if (pls[i] === 1'b1) pls_cnt[i]++;
        end
    end

    // Advance the model over one edge, then apply the next vector.
    task automatic edge_and_apply(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nr);
        @(posedge clk);
        if (cur_rst) begin
            m_q_and = '0; m_q_buf = '0; m_q_inv = '0;
            for (int k = 0; k < D; k++) m_hist[k] = '1;
        end else begin
            m_q_and = cur_a & cur_b; m_q_buf = cur_a; m_q_inv = ~cur_a;
            for (int k = D-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = ~cur_a;
        end
        #1;
        a = na; b = nb; reset = nr;
        cur_a = na; cur_b = nb; cur_rst = nr;
    endtask

    task automatic cyc(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nr);
        exp_t e;
        edge_and_apply(na, nb, nr);
        e.y_and = na & nb; e.y_buf = na; e.y_inv = ~na;
        e.q_and = m_q_and; e.q_buf = m_q_buf; e.q_inv = m_q_inv;
        e.pls   = (PEN != 0) ? (na & m_hist[D-1]) : '0;
        exp_q.push_back(e);
    endtask

    // Same timing, but the expectation is a hand-written vector.
    task automatic cyc_hand(input logic [W-1:0] na, input logic [W-1:0] nb, input exp_t he);
        edge_and_apply(na, nb, 1'b0);
        exp_q.push_back(he);
    endtask

    task automatic run(input logic [W-1:0] na, input logic nr, input int n);
        for (int i = 0; i < n; i++) cyc(na, 8'h00, nr);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < W; i++) pls_cnt[i] = 0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        exp_t h;
        int   others;
        reset = 1'b1; a = '0; b = '0;
        cur_rst = 1'b1; cur_a = '0; cur_b = '0;
        clr_cnt();

        // Reset state.
        run(8'h00, 1'b1, 3);

        // Truth table: first cycle shows reset q values, second the update.
        h = '{y_and:8'h30, y_buf:8'hF0, y_inv:8'h0F,
              q_and:8'h00, q_buf:8'h00, q_inv:8'h00,
              pls:(PEN != 0) ? 8'hF0 : 8'h00};
        cyc_hand(8'hF0, 8'h3C, h);
        h = '{y_and:8'h30, y_buf:8'hF0, y_inv:8'h0F,
              q_and:8'h30, q_buf:8'hF0, q_inv:8'h0F,
              pls:(PEN != 0) ? 8'hF0 : 8'h00};
        cyc_hand(8'hF0, 8'h3C, h);
        run(8'h00, 1'b0, 12);
        drain();

        // Reset with a held high, then release: 2 reset cycles + 10 after.
        clr_cnt();
        for (int i = 0; i < 2; i++) cyc(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 14; i++) cyc(8'hFF, 8'hFF, 1'b0);
        run(8'h00, 1'b0, 12);
        drain();
        for (int i = 0; i < W; i++)
            chk($sformatf("rst_hold_width_lane%0d", i), pls_cnt[i], (PEN != 0) ? 12 : 0);

        // Full pulse on lane 0.
        clr_cnt();
        run(8'h01, 1'b0, 20);
        run(8'h00, 1'b0, 12);
        drain();
        chk("full_pulse_width", pls_cnt[0], (PEN != 0) ? 10 : 0);
        others = 0;
        for (int i = 1; i < W; i++) others += pls_cnt[i];
        chk("full_pulse_other_lanes", others, 0);

        // Truncated pulse on lane 3.
        clr_cnt();
        run(8'h08, 1'b0, 4);
        run(8'h00, 1'b0, 12);
        drain();
        chk("trunc_pulse_width", pls_cnt[3], (PEN != 0) ? 4 : 0);

        // Re-trigger on lane 1 after a 3-cycle low.
        clr_cnt();
        run(8'h02, 1'b0, 15);
        run(8'h00, 1'b0, 3);
        drain();
        chk("retrig_first_width", pls_cnt[1], (PEN != 0) ? 10 : 0);
        clr_cnt();
        run(8'h02, 1'b0, 15);
        run(8'h00, 1'b0, 12);
        drain();
        chk("retrig_second_width", pls_cnt[1], (PEN != 0) ? 3 : 0);

        // Reset mid-pulse restarts it: 4 + 1 (reset cycle) + 10.
        clr_cnt();
        run(8'h01, 1'b0, 4);
        run(8'h01, 1'b1, 1);
        run(8'h01, 1'b0, 15);
        run(8'h00, 1'b0, 12);
        drain();
        chk("mid_reset_width", pls_cnt[0], (PEN != 0) ? 15 : 0);

        // Mixed toggling across lanes.
        run(8'hA5, 1'b0, 3);
        cyc(8'h5A, 8'hFF, 1'b0);
        cyc(8'hFF, 8'h0F, 1'b0);
        run(8'h00, 1'b0, 2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_std_and2_buf_inv
`default_nettype wire

// File: doc/std_and2_buf_inv.md
Name: std_and2_buf_inv

Overview:
- Parameterised bank of the three primitive cells AND2, BUF and INV, WIDTH lanes wide.
- Provides each cell's pure combinational outputs and a registered copy of each.
- Also provides a clocked rising-edge pulse shaper: the synchronous equivalent of the INV + BUF-chain + AND2 pulse damper used elsewhere in the design.
- Used as the common gate layer under the DCO, PFD and pulse-damper blocks.

Parameters:
- WIDTH, 8, number of independent lanes (>=1).
- DELAY_STAGES, 10, depth of the registered BUF chain, equal to the pulse width in clocks (>=1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, per lane.
- b  input  WIDTH  operand B, per lane (AND2 only).
- y_and  output  WIDTH  combinational a & b.
- y_buf  output  WIDTH  combinational a.
- y_inv  output  WIDTH  combinational ~a.
- q_and  output  WIDTH  registered a & b.
- q_buf  output  WIDTH  registered a.
- q_inv  output  WIDTH  registered ~a.
- pls  output  WIDTH  rising-edge pulse of a, DELAY_STAGES clocks wide.

Behaviour:
- Combinational outputs:
  - y_and, y_buf, y_inv are pure bitwise functions of the current inputs.
  - They have no dependency on clk or reset, including during reset.
- Registered outputs:
  - One-cycle latency: on each clk edge with reset=0, q_and<=a&b, q_buf<=a, q_inv<=~a.
  - On a clk edge with reset=1, all three go to 0. q_inv also resets to 0, not ~a.
  - The first valid q_inv appears on the first edge with reset=0.
- Pulse shaper, per lane i:
  - Register chain c[0..DELAY_STAGES-1].
  - c[0]<=~a[i] and c[k]<=c[k-1] on each edge.
  - pls[i] = a[i] & c[DELAY_STAGES-1]. This is combinational from a; the tail is registered.
  - Reset loads every chain stage with 1, meaning "a was low".
- Pulse width rules:
  - If a rises and stays high, pls is high from the rise until the DELAY_STAGES-th clk edge after the edge that first samples a=1, i.e. exactly DELAY_STAGES cycles.
  - pls then stays low while a stays high.
  - If a falls before DELAY_STAGES cycles, pls falls immediately with it (truncated pulse).
  - A new rise needs a low level to propagate through the chain. A re-rise after a low of L cycles gives a pulse of min(L, DELAY_STAGES) cycles.
  - If a is held high through reset, then after reset release pls is high for DELAY_STAGES cycles, because the chain is reloaded with 1s.
- Reset mid-operation: a pulse in flight is restarted, i.e. reloaded as if a had been low.
- Lanes are fully independent. There is no cross-lane logic.
- There is no X-propagation handling beyond standard bitwise semantics.

Optional Feature:
- Macro: STD_GATE_PULSE_EN.
- Defined: the pulse shaper and its chain registers are built as described above.
- Undefined: no chain registers are instantiated and pls is tied to all zeros.
- All other outputs are identical in both builds.

Decomposition:
- Package std_gate_pkg holds:
  - default constants STD_GATE_WIDTH_DEF=8 and STD_GATE_DLY_DEF=10;
  - the chain reset value constant (all ones).
- One sub-module, std_buf_chain:
  - WIDTH x DELAY_STAGES synchronous shift register with load-to-ones on reset;
  - output is the tail stage;
  - instantiated only under STD_GATE_PULSE_EN.

Test Plan:
- Truth table, WIDTH=8, reset=0: a=8'hF0, b=8'h3C -> y_and=8'h30, y_buf=8'hF0, y_inv=8'h0F. After one edge: q_and=8'h30, q_buf=8'hF0, q_inv=8'h0F.
- Reset: reset=1 for 2 edges with a=8'hFF, b=8'hFF -> q_and=q_buf=q_inv=0 and pls=0 only if a=0. Release -> q_* update on the next edge.
- Full pulse, DELAY_STAGES=10: a[0] 0->1 and held for 20 cycles -> pls[0]=1 for exactly 10 cycles, then 0. Other lanes stay 0.
- Truncated pulse: a[3] high for 4 cycles, then low -> pls[3]=1 for 4 cycles and drops with a.
- Re-trigger: a[1] high 15 cycles, low 3 cycles, high again -> second pulse lasts 3 cycles.
- Macro off: build without STD_GATE_PULSE_EN, toggle a -> pls stays 8'h00; gate outputs match the first scenario.
